// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem read handshake, holds
// an instruction across IF/ID stalls and squashes fetches on redirect/halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              Write_IF_ID,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instr,
  output logic              j_en,
  output logic              b_en,
  output logic              flush_IF_ID
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } hold_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t            state, state_nxt;
  hold_t             hold_q, hold_nxt;
  logic [WORD_W-1:0] pc_reg, pc_nxt;
  logic [WORD_W-1:0] pc_o, instr_o;
  logic              ren, flush, flush_o;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_reg <= WORD_W'(RESET_PC);
      state  <= FETCH;
      hold_q <= '0;
    end else begin
      pc_reg <= pc_nxt;
      state  <= state_nxt;
      hold_q <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    hold_nxt  = hold_q;
    ren       = 1'b0;
    flush     = 1'b1;
    pc_o      = pc_reg;
    instr_o   = '0;
    case (state)
      FETCH: begin
        ren = 1'b1;
        if (ihit) begin
          instr_o = iload;
          flush   = 1'b0;
          if (Write_IF_ID) begin
            pc_nxt = pc_reg + WORD_W'(4);
          end else begin
            hold_nxt  = '{pc: pc_reg, instr: iload};
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        pc_o    = hold_q.pc;
        instr_o = hold_q.instr;
        flush   = 1'b0;
        if (Write_IF_ID) begin
          pc_nxt    = hold_q.pc + WORD_W'(4);
          state_nxt = FETCH;
        end
      end
      default: ;
    endcase
    // halt outranks redirect; both squash whatever would have been presented
    if (state != HALTED) begin
      if (halt) begin
        state_nxt = HALTED;
        pc_nxt    = pc_reg;
        hold_nxt  = hold_q;
        flush     = 1'b1;
        pc_o      = pc_reg;
        instr_o   = '0;
      end else if (redirect) begin
        state_nxt = FETCH;
        pc_nxt    = redirect_pc;
        hold_nxt  = '0;
        flush     = 1'b1;
        pc_o      = pc_reg;
        instr_o   = '0;
      end
    end
  end

  // outputs are combinational, so the async reset must also gate them directly
  assign flush_o     = !nRST || flush;
  assign flush_IF_ID = flush_o;
  assign iREN        = nRST && ren;
  assign iaddr       = pc_reg;
  assign pc          = nRST ? pc_o : '0;
  assign instr       = nRST ? instr_o : '0;
  assign j_en        = !flush_o && (instr_o[6:0] == OP_JAL || instr_o[6:0] == OP_JALR);
  assign b_en        = !flush_o && (instr_o[6:0] == OP_BRANCH);

endmodule
